aes_128_feeder: RTL and testbench

AES_128_FEEDER -- requirements
Module: aes_128_feeder

---
 rtl/aes_128_feeder.sv | 132 +++++++++++++
 tb/tb_aes_128_feeder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_feeder.sv
// aes_128_feeder: packs 32-bit words into 128-bit blocks for an aes_128
// core, tracks its fixed latency and buffers the ciphertexts.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   key_in/valid/ready      cipher key, taken only when the core is idle
//   din/valid/ready         plaintext words, first word is the block MSW
//   core_state/key/out      registered core inputs and core result
//   dout/valid/ready        ciphertext at the result buffer head
//   busy                    partial block, in-flight block or buffered result

module aes_128_feeder #(
  parameter int LATENCY = 20,
  parameter int DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [31:0]  din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic [127:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]         wcnt;
  logic [127:0]       block;
  logic [LATENCY-1:0] sr;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      count;
  logic [PW-1:0]      wp;
  logic [PW-1:0]      rp;
  logic [127:0]       mem [DEPTH];

  logic        din_acc;
  logic        key_acc;
  logic        issue;
  logic        push;
  logic        pop;
  logic [CW:0] used;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign din_ready  = (wcnt < 3'd4);
  assign key_ready  = (inflight == '0) && (wcnt == 3'd0);
  assign dout_valid = (count != '0);
  assign dout       = mem[rp];
  assign busy       = (wcnt != 3'd0) || (inflight != '0)
                   || (count != '0);

  assign din_acc = din_valid && din_ready;
  assign key_acc = key_valid && key_ready;
  assign push    = sr[LATENCY-1];
  assign pop     = dout_valid && dout_ready;

  // Credit: every in-flight block already owns a buffer slot, so the
  // buffer can never be full when a result lands.
  assign used  = {1'b0, inflight} + {1'b0, count};
  assign issue = (wcnt == 3'd4) && (used < (CW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt       <= 3'd0;
      block      <= '0;
      sr         <= '0;
      inflight   <= '0;
      count      <= '0;
      wp         <= '0;
      rp         <= '0;
      core_state <= '0;
      core_key   <= '0;
    end else begin
      sr <= (sr << 1) | LATENCY'(issue);

      if (issue) begin
        core_state <= block;
        wcnt       <= 3'd0;
      end else if (din_acc) begin
        wcnt <= wcnt + 3'd1;
        unique case (wcnt[1:0])
          2'd0: block[127:96] <= din;
          2'd1: block[95:64]  <= din;
          2'd2: block[63:32]  <= din;
          2'd3: block[31:0]   <= din;
        endcase
      end

      if (key_acc) begin
        core_key <= key_in;
      end

      unique case (1'b1)
        (issue && !push): inflight <= inflight + 1'b1;
        (push && !issue): inflight <= inflight - 1'b1;
        default:          inflight <= inflight;
      endcase

      unique case (1'b1)
        (push && !pop): count <= count + 1'b1;
        (pop && !push): count <= count - 1'b1;
        default:        count <= count;
      endcase

      if (push) begin
        wp <= bump(wp);
      end
      if (pop) begin
        rp <= bump(rp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= core_out;
    end
  end

endmodule

// File: tb/tb_aes_128_feeder.sv
// tb_aes_128_feeder: random and directed stimulus for aes_128_feeder,
// checked every cycle against a queue-based transaction model.

module tb_aes_128_feeder;

  localparam int LAT = 12;
  localparam int DEP = 4;

  localparam logic [127:0] FKEY =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FPT =
    128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FCT =
    128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [31:0]  din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [127:0] core_state;
  logic [127:0] core_key;
  logic [127:0] core_out;
  logic [127:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_128_feeder #(
    .LATENCY(LAT),
    .DEPTH  (DEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .core_state(core_state),
    .core_key  (core_key),
    .core_out  (core_out),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy      (busy)
  );

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Stand-in cipher: knows the FIPS-197 vector, mixes anything else.
  function automatic logic [127:0] ciph(input logic [127:0] s,
                                        input logic [127:0] k);
    if (s == FPT && k == FKEY) return FCT;
    return {s[90:0], s[127:91]} ^ {k[31:0], k[127:32]}
         ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // Core model: result appears LAT-1 edges after core_state changes.
  logic [127:0] pipe [LAT-1];
  always @(posedge clk) begin
    pipe[0] <= ciph(core_state, core_key);
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out = pipe[LAT-2];

  // Transaction model: pending words, in-flight blocks, result queue.
  logic [31:0]  mw[$];
  int           mrem[$];
  logic [127:0] mct[$];
  logic [127:0] mbuf[$];
  logic [127:0] mkey = '0;
  logic [127:0] mcs = '0;
  logic [127:0] blk;
  bit           armed = 0;
  bit           m_iss, m_pop, m_kacc, m_dacc;

  always @(negedge clk) begin
    if (armed) begin
      chk("din_ready", din_ready, mw.size() < 4);
      chk("key_ready", key_ready,
          mrem.size() == 0 && mw.size() == 0);
      chk("dout_valid", dout_valid, mbuf.size() != 0);
      if (mbuf.size() != 0) chk("dout", dout, mbuf[0]);
      chk("busy", busy, mw.size() != 0 || mrem.size() != 0
                        || mbuf.size() != 0);
      chk("core_state", core_state, mcs);
      chk("core_key", core_key, mkey);
    end
    if (!rst_n) begin
      mw.delete(); mrem.delete(); mct.delete(); mbuf.delete();
      mkey = '0; mcs = '0; armed = 1;
    end else if (armed) begin
      m_pop  = mbuf.size() != 0 && dout_ready;
      m_iss  = mw.size() == 4 && mrem.size() + mbuf.size() < DEP;
      m_kacc = key_valid && mrem.size() == 0 && mw.size() == 0;
      m_dacc = din_valid && mw.size() < 4;
      if (m_pop) void'(mbuf.pop_front());
      foreach (mrem[i]) mrem[i]--;
      if (mrem.size() > 0 && mrem[0] == 0) begin
        void'(mrem.pop_front());
        mbuf.push_back(mct.pop_front());
      end
      if (m_iss) begin
        blk = {mw[0], mw[1], mw[2], mw[3]};
        mcs = blk;
        mrem.push_back(LAT);
        mct.push_back(ciph(blk, mkey));
        mw.delete();
      end
      if (m_dacc) mw.push_back(din);
      if (m_kacc) mkey = key_in;
    end
  end

  // Observers: issue times (core_state changes) and dout handshakes.
  logic [127:0] prev_cs = '0;
  int iss_t[$];
  int npop = 0;
  always @(negedge clk) begin
    if (core_state !== prev_cs) iss_t.push_back(cyc);
    prev_cs = core_state;
    if (dout_valid && dout_ready) npop++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [31:0] w);
    bit ok;
    int n;
    ok = 0; n = 0;
    din = w; din_valid = 1'b1;
    while (!ok && n < 60) begin
      @(negedge clk);
      ok = din_ready;
      @(posedge clk); #1;
      n++;
    end
    din_valid = 1'b0;
    chk("din_accept", ok, 1);
  endtask

  task automatic put_block(input logic [127:0] b);
    put_word(b[127:96]);
    put_word(b[95:64]);
    put_word(b[63:32]);
    put_word(b[31:0]);
  endtask

  task automatic put_key(input logic [127:0] k);
    bit ok;
    int n;
    ok = 0; n = 0;
    key_in = k; key_valid = 1'b1;
    while (!ok && n < 60) begin
      @(negedge clk);
      ok = key_ready;
      @(posedge clk); #1;
      n++;
    end
    key_valid = 1'b0;
    chk("key_accept", ok, 1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int w4;
  int n;
  bit seen;
  logic [127:0] k2;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_din_ready", din_ready, 1);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_state", core_state, 0);
    chk("rst_core_key", core_key, 0);
    @(posedge clk); #1;

    // FIPS-197 vector and result latency.
    dout_ready = 1'b1;
    put_key(FKEY);
    put_block(FPT);
    w4 = cyc;
    n = 0;
    while (!dout_valid && n < 60) begin
      @(negedge clk); n++;
    end
    chk("fips_valid", dout_valid, 1);
    chk("fips_latency", cyc - w4, LAT + 1);
    chk("fips_dout", dout, FCT);
    @(posedge clk); #1;

    // Key gating while a block is in flight.
    put_block(rnd128());
    w4 = cyc;
    k2 = rnd128();
    key_in = k2; key_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < 60) begin
      chk("kg_core_key", core_key, FKEY);
      @(negedge clk); n++;
    end
    chk("kg_wait", cyc - w4, LAT + 1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    @(negedge clk);
    chk("kg_new_key", core_key, k2);
    @(posedge clk); #1;

    // Back-pressure: 4 issue, the 5th waits assembled.
    dout_ready = 1'b0;
    iss_t.delete();
    repeat (5) put_block(rnd128());
    step(LAT + 4);
    chk("bp_issued", iss_t.size(), 4);
    @(negedge clk);
    chk("bp_din_ready", din_ready, 0);
    chk("bp_dout_valid", dout_valid, 1);
    @(posedge clk); #1;
    npop = 0;
    dout_ready = 1'b1;
    put_block(rnd128());
    step(3 * LAT + 20);
    chk("bp_issued_all", iss_t.size(), 6);
    chk("bp_drained", npop, 6);

    // Push and pop on one edge with the buffer at DEPTH-1.
    dout_ready = 1'b0;
    repeat (DEP - 1) put_block(rnd128());
    step(LAT + 3);
    put_block(rnd128());
    step(LAT);
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    npop = 0;
    dout_ready = 1'b1;
    step(10);
    chk("pp_drain", npop, DEP - 1);

    // Reset with two blocks in flight.
    put_block(rnd128());
    put_block(rnd128());
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (dout_valid || busy) seen = 1;
    end
    chk("rmf_quiet", seen, 0);
    chk("rmf_busy", busy, 0);
    @(posedge clk); #1;

    // Streaming: 8 back-to-back blocks.
    iss_t.delete();
    repeat (8) put_block(rnd128());
    step(LAT + 5);
    chk("st_issued", iss_t.size(), 8);
    for (int i = 1; i < 8 && i < iss_t.size(); i++)
      chk("st_gap", iss_t[i] - iss_t[i-1], 5);

    // Random traffic, occasional key loads and resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom % 500) != 0;
      key_valid  = ($urandom % 16) == 0;
      key_in     = rnd128();
      din_valid  = ($urandom % 4) != 0;
      din        = $urandom;
      dout_ready = ($urandom % 8) < ((i / 200) % 8 + 1);
      step(1);
    end
    rst_n = 1'b1; key_valid = 1'b0; din_valid = 1'b0;
    dout_ready = 1'b1;
    step(3 * LAT);
    @(negedge clk);
    chk("end_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
